// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with per-slot blanking guard.
// Inputs are shadowed once per frame so a digit never tears mid-scan.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_mask,
  output logic [1:0]  sel,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   sh_bcd_q, sh_bcd_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic [3:0]    sh_mask_q, sh_mask_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          fd_q, fd_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    digit;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      sh_bcd_q  <= '0;
      sh_dp_q   <= '0;
      sh_mask_q <= '0;
      an_n_q    <= '1;
      seg_n_q   <= '1;
      dp_n_q    <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      sh_bcd_q  <= sh_bcd_d;
      sh_dp_q   <= sh_dp_d;
      sh_mask_q <= sh_mask_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      fd_q      <= fd_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    sh_bcd_d  = sh_bcd_q;
    sh_dp_d   = sh_dp_q;
    sh_mask_d = sh_mask_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = GUARD;
          cnt_d     = '0;
          sel_d     = '0;
          sh_bcd_d  = bcd_in;
          sh_dp_d   = dp_in;
          sh_mask_d = digit_mask;
        end
        default: begin
          if (cnt_q == CNT_LAST) begin
            state_d = GUARD;
            cnt_d   = '0;
            sel_d   = sel_q + 2'd1;
            if (sel_q == 2'd3) begin
              sh_bcd_d  = bcd_in;
              sh_dp_d   = dp_in;
              sh_mask_d = digit_mask;
            end
          end else begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc >= CNT_BLANK) ? DRIVE : GUARD;
          end
        end
      endcase
    end
  end

  // Outputs are decoded from next-state values so the registered pins line up with state_q/cnt_q.
  always_comb begin
    digit   = sh_bcd_d[{sel_d, 2'b00} +: 4];
    an_n_d  = '1;
    seg_n_d = '1;
    dp_n_d  = 1'b1;
    fd_d    = (state_d == DRIVE) && (sel_d == 2'd3) && (cnt_d == CNT_LAST);
    if ((state_d == DRIVE) && !sh_mask_d[sel_d]) begin
      an_n_d  = ~(4'b0001 << sel_d);
      seg_n_d = ~seg_of(digit);
      dp_n_d  = ~sh_dp_d[sel_d];
    end
  end

  assign sel        = sel_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = fd_q;

endmodule
